update_release_arb: RTL and testbench
=====================================

Name: update_release_arb

Overview:
- Next-generation VC update/release arbiter for the router output-port stage.
- Owns the per-output-VC busy tags internally, so no external tag register is needed.
- Each cycle: grants at most one input port a free VC from that port's allowed set (work-conserving round-robin), and clears tags for VCs released by any input port.
- Grant outputs are registered. The block feeds the VC allocator and the crossbar setup logic.

Parameters:
- no_inport, 6, number of input ports contending for this output port
- floorplusone_log2_no_inport, 3, width of a port index
- no_vc, 13, number of output VCs
- floorplusone_log2_no_vc, 4, width of a VC index

Ports:
- clk  in  1  clock, rising edge
- rs  in  1  reset; asynchronous, active-low
- updates  in  no_inport  per-port allocation request
- invc_nos  in  no_inport*floorplusone_log2_no_vc  packed requesting input-VC number per port
- all_allowed_vcs  in  no_inport*no_vc  packed allowed-output-VC mask per port
- releases  in  no_inport  per-port VC release strobe
- rel_vc_nos  in  no_inport*floorplusone_log2_no_vc  packed released output-VC number per port
- update_en  out  1  registered: a grant occurred last cycle
- ok  out  no_inport  registered one-hot grant
- port_no_vec  out  no_inport  identical to ok
- vc_no  out  floorplusone_log2_no_vc  registered invc_nos of winner
- out_vc_no  out  floorplusone_log2_no_vc  registered allocated output-VC index
- tags  out  no_vc  current busy vector (register)
- rel_err  out  1  sticky: an illegal release was seen

Behaviour:
- Reset (rs low, async): tags=0, pointer=0, update_en/ok/port_no_vec/vc_no/out_vc_no=0, rel_err=0. Reset mid-operation drops any pending grant; no grant output in the cycle after rs rises.
- rel_mask: OR over ports of one-hot(rel_vc_nos[i]) gated by releases[i]. Indices >= no_vc are ignored and set rel_err.
- Releasing a VC whose tag is 0 sets rel_err; tags are unchanged for that VC.
- Two ports releasing the same busy VC in one cycle: single clear, no error.
- tags_eff = tags (bypass disabled).
- eligible[i] = updates[i] & ~ok[i] & |(allowed[i] & ~tags_eff).
  - Masking with registered ok prevents a re-grant while the requester drops updates.
- Winner: first eligible port scanning from pointer upward, cyclic.
- Allocated VC: lowest-index bit of allowed[winner] & ~tags_eff.
- At the clock edge when a winner exists:
  - ok <= one-hot(winner); update_en <= 1.
  - vc_no <= invc_nos[winner]; out_vc_no <= allocated VC.
  - pointer <= (winner+1) mod no_inport, wrapping no_inport-1 -> 0.
- No winner: update_en, ok, vc_no and out_vc_no <= 0; pointer held.
- Tag update each edge: tags <= (tags & ~rel_mask) | grant_onehot.
- Latency: request at cycle t -> ok/out_vc_no visible at t+1, for exactly one cycle. A requester must deassert updates in the cycle it sees ok.
- All VCs busy: no grant; requests wait without loss of pointer position.

Optional Feature:
- Macro: UPDATE_RELEASE_BYPASS_EN.
- Defined: tags_eff = tags & ~rel_mask, so a VC released in cycle t is grantable in cycle t. The grant bit wins over the release clear in the tags update.
- Undefined: a released VC is grantable from t+1.

Decomposition:
- Shared header/package update_release_defs:
  - width constants, mirroring the parameter defaults
  - packed-field slice macros for invc_nos, all_allowed_vcs and rel_vc_nos
- One sub-module: rr_pick, a parametrised rotate-priority one-hot picker.
  - Inputs: request vector, pointer. Outputs: one-hot grant, index.
  - Instantiated for port selection.
- Lowest-free-VC selection stays an inline priority encoder.

Test Plan:
- Reset, then updates=6'b000001, allowed[0]=13'h0003 -> next cycle ok=000001, out_vc_no=0, tags=0x0001, pointer=1.
- All six ports request, all VCs free, held asserted with requester drop -> grants in order ports 0,1,2,3,4,5 on consecutive cycles, out_vc_no 0..5, tags=0x003F.
- tags full (0x1FFF), port 2 requests; release VC 7 at cycle t:
  - macro off: grant at t+2, out_vc_no=7
  - macro on: grant at t+1, out_vc_no=7, tags stays 0x1FFF
- Release of free VC 4, and release with rel_vc_nos=15 -> rel_err=1 sticky, tags unchanged until reset.
- Ports 1 and 4 release VC 3 the same cycle -> tags bit 3 cleared once, rel_err=0.
- Assert rs low while update_en=1 -> all outputs and tags 0 immediately (async). After rs rises, the first grant starts from port 0.

Source files
------------

// File: rtl/update_release_arb_pkg.sv
// Shared width constants and packed-field slice helper for update_release_arb.
package update_release_arb_pkg;
  localparam int NO_INPORT = 6;
  localparam int PORT_W    = 3;
  localparam int NO_VC     = 13;
  localparam int VC_W      = 4;
endpackage

`define URA_FIELD(vec, idx, w) vec[(idx)*(w) +: (w)]

// File: rtl/update_release_arb_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr, wrapping cyclically.
module rr_pick #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      pos = sum[IDX_W-1:0];
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end
endmodule

// File: rtl/update_release_arb.sv
// Output-port VC update/release arbiter owning the per-VC busy tags.
// Optional same-cycle release-to-grant bypass: define UPDATE_RELEASE_BYPASS_EN.
module update_release_arb
  import update_release_arb_pkg::*;
#(
  parameter int no_inport                   = NO_INPORT,
  parameter int floorplusone_log2_no_inport = PORT_W,
  parameter int no_vc                       = NO_VC,
  parameter int floorplusone_log2_no_vc     = VC_W
) (
  input  logic                                         clk,
  input  logic                                         rs,
  input  logic [no_inport-1:0]                         updates,
  input  logic [no_inport*floorplusone_log2_no_vc-1:0] invc_nos,
  input  logic [no_inport*no_vc-1:0]                   all_allowed_vcs,
  input  logic [no_inport-1:0]                         releases,
  input  logic [no_inport*floorplusone_log2_no_vc-1:0] rel_vc_nos,
  output logic                                         update_en,
  output logic [no_inport-1:0]                         ok,
  output logic [no_inport-1:0]                         port_no_vec,
  output logic [floorplusone_log2_no_vc-1:0]           vc_no,
  output logic [floorplusone_log2_no_vc-1:0]           out_vc_no,
  output logic [no_vc-1:0]                             tags,
  output logic                                         rel_err
);
  localparam int PW  = floorplusone_log2_no_inport;
  localparam int VCW = floorplusone_log2_no_vc;

  logic [PW-1:0]        ptr;
  logic [PW-1:0]        ptr_nxt;
  logic [no_vc-1:0]     rel_mask;
  logic                 rel_bad;
  logic [no_vc-1:0]     tags_eff;
  logic [no_inport-1:0] eligible;
  logic [no_inport-1:0] port_grant;
  logic [PW-1:0]        winner;
  logic                 found;
  logic [no_vc-1:0]     free_sel;
  logic [VCW-1:0]       invc_sel;
  logic [no_vc-1:0]     vc_grant;
  logic [VCW-1:0]       vc_sel;

  // Release decode: out-of-range indices and releases of free VCs are flagged.
  always_comb begin
    rel_mask = '0;
    rel_bad  = 1'b0;
    for (int i = 0; i < no_inport; i++) begin
      if (releases[i]) begin
        if (int'(`URA_FIELD(rel_vc_nos, i, VCW)) < no_vc) begin
          rel_mask[`URA_FIELD(rel_vc_nos, i, VCW)] = 1'b1;
          if (!tags[`URA_FIELD(rel_vc_nos, i, VCW)]) rel_bad = 1'b1;
        end else begin
          rel_bad = 1'b1;
        end
      end
    end
  end

`ifdef UPDATE_RELEASE_BYPASS_EN
  assign tags_eff = tags & ~rel_mask;
`else
  assign tags_eff = tags;
`endif

  // Registered ok masks the port just granted so it cannot win twice in a row.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < no_inport; i++)
      eligible[i] = updates[i] & ~ok[i] &
                    (|(`URA_FIELD(all_allowed_vcs, i, no_vc) & ~tags_eff));
  end

  rr_pick #(
    .N     (no_inport),
    .IDX_W (PW)
  ) u_port_pick (
    .req   (eligible),
    .ptr   (ptr),
    .grant (port_grant),
    .idx   (winner),
    .found (found)
  );

  always_comb begin
    free_sel = '0;
    invc_sel = '0;
    for (int i = 0; i < no_inport; i++) begin
      if (port_grant[i]) begin
        free_sel = `URA_FIELD(all_allowed_vcs, i, no_vc) & ~tags_eff;
        invc_sel = `URA_FIELD(invc_nos, i, VCW);
      end
    end
  end

  // Lowest free allowed VC: the downward scan leaves the smallest index last.
  always_comb begin
    vc_grant = '0;
    vc_sel   = '0;
    for (int v = no_vc - 1; v >= 0; v--) begin
      if (free_sel[v]) begin
        vc_grant    = '0;
        vc_grant[v] = 1'b1;
        vc_sel      = VCW'(v);
      end
    end
  end

  assign ptr_nxt = (winner == PW'(no_inport - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      ptr       <= '0;
      update_en <= 1'b0;
      ok        <= '0;
      vc_no     <= '0;
      out_vc_no <= '0;
      tags      <= '0;
      rel_err   <= 1'b0;
    end else begin
      update_en <= found;
      ok        <= port_grant;
      vc_no     <= invc_sel;
      out_vc_no <= vc_sel;
      if (found) ptr <= ptr_nxt;
      tags      <= (tags & ~rel_mask) | vc_grant;
      rel_err   <= rel_err | rel_bad;
    end
  end

  assign port_no_vec = ok;
endmodule

// File: tb/tb_update_release_arb.sv
// Directed self-checking bench for update_release_arb.
module tb_update_release_arb;
  logic        clk = 1'b0;
  logic        rs  = 1'b1;
  logic [5:0]  updates = '0;
  logic [23:0] invc_nos = '0;
  logic [77:0] all_allowed_vcs = '0;
  logic [5:0]  releases = '0;
  logic [23:0] rel_vc_nos = '0;
  logic        update_en;
  logic [5:0]  ok;
  logic [5:0]  port_no_vec;
  logic [3:0]  vc_no;
  logic [3:0]  out_vc_no;
  logic [12:0] tags;
  logic        rel_err;

  int errors = 0;
  int checks = 0;

  update_release_arb dut (
    .clk             (clk),
    .rs              (rs),
    .updates         (updates),
    .invc_nos        (invc_nos),
    .all_allowed_vcs (all_allowed_vcs),
    .releases        (releases),
    .rel_vc_nos      (rel_vc_nos),
    .update_en       (update_en),
    .ok              (ok),
    .port_no_vec     (port_no_vec),
    .vc_no           (vc_no),
    .out_vc_no       (out_vc_no),
    .tags            (tags),
    .rel_err         (rel_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rs = 1'b0;
    updates = '0;
    releases = '0;
    invc_nos = '0;
    rel_vc_nos = '0;
    all_allowed_vcs = '0;
    step();
    rs = 1'b1;
  endtask

  task automatic fill_vcs(input int n);
    all_allowed_vcs[0 +: 13] = 13'h1FFF;
    for (int k = 0; k < n; k++) begin
      updates = 6'b000001;
      step();
      updates = '0;
      step();
    end
  endtask

  task automatic test_reset();
    #2 rs = 1'b0;
    #1;
    checks++; if (update_en !== 1'b0) begin errors++; $display("FAIL reset_update_en: got %b want 0", update_en); end
    checks++; if (ok !== 6'b0) begin errors++; $display("FAIL reset_ok: got %b want 000000", ok); end
    checks++; if (port_no_vec !== 6'b0) begin errors++; $display("FAIL reset_port_no_vec: got %b want 000000", port_no_vec); end
    checks++; if (vc_no !== 4'd0 || out_vc_no !== 4'd0) begin errors++; $display("FAIL reset_vc: got vc_no=%0d out_vc_no=%0d want 0/0", vc_no, out_vc_no); end
    checks++; if (tags !== 13'h0) begin errors++; $display("FAIL reset_tags: got %h want 0000", tags); end
    checks++; if (rel_err !== 1'b0) begin errors++; $display("FAIL reset_rel_err: got %b want 0", rel_err); end
    step();
    rs = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    invc_nos[0 +: 4] = 4'd5;
    all_allowed_vcs[0 +: 13] = 13'h0003;
    updates = 6'b000001;
    step();
    checks++; if (ok !== 6'b000001 || port_no_vec !== 6'b000001) begin errors++; $display("FAIL single_ok: got ok=%b pnv=%b want 000001", ok, port_no_vec); end
    checks++; if (update_en !== 1'b1) begin errors++; $display("FAIL single_update_en: got %b want 1", update_en); end
    checks++; if (out_vc_no !== 4'd0 || vc_no !== 4'd5) begin errors++; $display("FAIL single_vc: got out_vc_no=%0d vc_no=%0d want 0/5", out_vc_no, vc_no); end
    checks++; if (tags !== 13'h0001) begin errors++; $display("FAIL single_tags: got %h want 0001", tags); end
    updates = '0;
    step();
    checks++; if (update_en !== 1'b0 || ok !== 6'b0) begin errors++; $display("FAIL single_one_cycle: got update_en=%b ok=%b want 0/000000", update_en, ok); end
    // pointer now at port 1: ports 0 and 1 both ask, port 1 should win
    all_allowed_vcs[13 +: 13] = 13'h0003;
    updates = 6'b000011;
    step();
    checks++; if (ok !== 6'b000010 || out_vc_no !== 4'd1) begin errors++; $display("FAIL single_pointer: got ok=%b out_vc_no=%0d want 000010/1", ok, out_vc_no); end
    updates = '0;
    step();
  endtask

  task automatic test_all_ports();
    logic [5:0] exp_ok;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      all_allowed_vcs[i*13 +: 13] = 13'h1FFF;
      invc_nos[i*4 +: 4] = 4'(i + 8);
    end
    updates = 6'b111111;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_ok = 6'(1 << k);
      checks++; if (ok !== exp_ok || out_vc_no !== 4'(k) || vc_no !== 4'(k + 8)) begin
        errors++; $display("FAIL all_ports_%0d: got ok=%b out_vc_no=%0d vc_no=%0d want %b/%0d/%0d", k, ok, out_vc_no, vc_no, exp_ok, k, k + 8);
      end
      updates[k] = 1'b0;
    end
    checks++; if (tags !== 13'h003F) begin errors++; $display("FAIL all_ports_tags: got %h want 003f", tags); end
    updates = 6'b001001;
    step();
    checks++; if (ok !== 6'b000001 || out_vc_no !== 4'd6) begin errors++; $display("FAIL pointer_wrap: got ok=%b out_vc_no=%0d want 000001/6", ok, out_vc_no); end
    checks++; if (tags !== 13'h007F) begin errors++; $display("FAIL pointer_wrap_tags: got %h want 007f", tags); end
    updates = '0;
    step();
  endtask

  task automatic test_release_full();
    apply_reset();
    fill_vcs(13);
    checks++; if (tags !== 13'h1FFF) begin errors++; $display("FAIL full_tags: got %h want 1fff", tags); end
    all_allowed_vcs[26 +: 13] = 13'h1FFF;
    invc_nos[8 +: 4] = 4'd3;
    updates = 6'b000100;
    step();
    checks++; if (update_en !== 1'b0) begin errors++; $display("FAIL full_no_grant: got %b want 0", update_en); end
    releases = 6'b000001;
    rel_vc_nos[0 +: 4] = 4'd7;
    step();
    releases = '0;
`ifdef UPDATE_RELEASE_BYPASS_EN
    checks++; if (update_en !== 1'b1 || ok !== 6'b000100 || out_vc_no !== 4'd7) begin errors++; $display("FAIL bypass_grant: got en=%b ok=%b out_vc_no=%0d want 1/000100/7", update_en, ok, out_vc_no); end
    checks++; if (tags !== 13'h1FFF) begin errors++; $display("FAIL bypass_tags: got %h want 1fff", tags); end
`else
    checks++; if (update_en !== 1'b0) begin errors++; $display("FAIL release_early_grant: got %b want 0", update_en); end
    checks++; if (tags !== 13'h1F7F) begin errors++; $display("FAIL release_tags: got %h want 1f7f", tags); end
    step();
    checks++; if (update_en !== 1'b1 || ok !== 6'b000100 || out_vc_no !== 4'd7) begin errors++; $display("FAIL release_grant: got en=%b ok=%b out_vc_no=%0d want 1/000100/7", update_en, ok, out_vc_no); end
    checks++; if (tags !== 13'h1FFF) begin errors++; $display("FAIL release_regrant_tags: got %h want 1fff", tags); end
`endif
    updates = '0;
    checks++; if (rel_err !== 1'b0 || vc_no !== 4'd3) begin errors++; $display("FAIL release_legal: got rel_err=%b vc_no=%0d want 0/3", rel_err, vc_no); end
    step();
  endtask

  task automatic test_rel_err();
    apply_reset();
    fill_vcs(1);
    releases = 6'b000001;
    rel_vc_nos[0 +: 4] = 4'd4;
    step();
    releases = '0;
    checks++; if (rel_err !== 1'b1 || tags !== 13'h0001) begin errors++; $display("FAIL free_release: got rel_err=%b tags=%h want 1/0001", rel_err, tags); end
    step(); step(); step();
    checks++; if (rel_err !== 1'b1 || tags !== 13'h0001) begin errors++; $display("FAIL rel_err_sticky: got rel_err=%b tags=%h want 1/0001", rel_err, tags); end
    apply_reset();
    checks++; if (rel_err !== 1'b0) begin errors++; $display("FAIL rel_err_cleared: got %b want 0", rel_err); end
    fill_vcs(1);
    releases = 6'b001000;
    rel_vc_nos[12 +: 4] = 4'd15;
    step();
    releases = '0;
    checks++; if (rel_err !== 1'b1 || tags !== 13'h0001) begin errors++; $display("FAIL range_release: got rel_err=%b tags=%h want 1/0001", rel_err, tags); end
  endtask

  task automatic test_dual_release();
    apply_reset();
    fill_vcs(4);
    checks++; if (tags !== 13'h000F) begin errors++; $display("FAIL dual_setup_tags: got %h want 000f", tags); end
    releases = 6'b010010;
    rel_vc_nos[4 +: 4]  = 4'd3;
    rel_vc_nos[16 +: 4] = 4'd3;
    step();
    releases = '0;
    checks++; if (tags !== 13'h0007 || rel_err !== 1'b0) begin errors++; $display("FAIL dual_release: got tags=%h rel_err=%b want 0007/0", tags, rel_err); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    all_allowed_vcs[0 +: 13]  = 13'h1FFF;
    all_allowed_vcs[13 +: 13] = 13'h1FFF;
    updates = 6'b000001;
    step();
    checks++; if (update_en !== 1'b1) begin errors++; $display("FAIL async_setup: got %b want 1", update_en); end
    #2 rs = 1'b0;
    #1;
    checks++; if (update_en !== 1'b0 || ok !== 6'b0 || port_no_vec !== 6'b0) begin errors++; $display("FAIL async_grant_clear: got en=%b ok=%b pnv=%b want 0", update_en, ok, port_no_vec); end
    checks++; if (tags !== 13'h0 || out_vc_no !== 4'd0 || vc_no !== 4'd0) begin errors++; $display("FAIL async_state_clear: got tags=%h out_vc_no=%0d vc_no=%0d want 0", tags, out_vc_no, vc_no); end
    updates = 6'b000011;
    @(posedge clk);
    #1 rs = 1'b1;
    step();
    checks++; if (ok !== 6'b000001 || out_vc_no !== 4'd0) begin errors++; $display("FAIL async_first_grant: got ok=%b out_vc_no=%0d want 000001/0", ok, out_vc_no); end
    updates = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ports();
    test_release_full();
    test_rel_err();
    test_dual_release();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
